pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives hold and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory waits. A wait that runs too long produces a sticky timeout, and the block also keeps performance counters for stall and flush cycles.

---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types and constants.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_e;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [4:0] X0 = 5'd0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and data-memory-busy detection.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic [1:0] ex_wdsel,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       load_use,
    output logic       mem_busy
);
    always_comb begin
        load_use = ex_regwrite && ex_wdsel == WD_MEM && ex_rd != X0 &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        mem_busy = mem_req && !mem_ready;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with memory-wait timeout and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_wdsel,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             load_use, mem_busy, hold, run_dec, br, lu;
    hazard_detect u_hd (
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_wdsel(ex_wdsel),
        .mem_req(mem_req), .mem_ready(mem_ready), .load_use(load_use), .mem_busy(mem_busy)
    );
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        hold       = 1'b0;
        run_dec    = 1'b0;
        case (state_q)
            RUN: begin
                hold       = mem_busy;
                run_dec    = !mem_busy;
                state_d    = mem_busy ? MEM_WAIT : RUN;
                wait_cnt_d = mem_busy ? 8'd1 : wait_cnt_q;
            end
            MEM_WAIT: begin
                // mem_ready is the release cycle: normal RUN decode applies with memory treated idle
                hold       = !mem_ready;
                run_dec    = mem_ready;
                wait_cnt_d = mem_ready ? 8'd0 : wait_cnt_q + 8'd1;
                if (mem_ready) state_d = RUN;
                else if (wait_cnt_q == 8'(MAX_WAIT)) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            HALT: hold = 1'b1;
            default: state_d = RUN;
        endcase
        br          = run_dec && ex_branch_taken;
        lu          = run_dec && !ex_branch_taken && load_use;
        pc_stall    = !rst && (hold || lu);
        ifid_stall  = !rst && (hold || lu);
        idex_stall  = !rst && hold;
        exmem_stall = !rst && hold;
        memwb_flush = rst || hold;
        ifid_flush  = rst || br;
        idex_flush  = rst || br || lu;
        stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush || idex_flush);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random stimulus, reference model feeds a scoreboard checked by a monitor.
module tb_pipe_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 8;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_regwrite = 0, ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic [1:0] ex_wdsel = 0;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_wdsel(ex_wdsel),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
        .memwb_flush(memwb_flush), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] o;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0, cyc = 0;

    // reference model: waiting/halted flags, count of wait cycles seen, counters
    bit waiting = 0, halted = 0, timed_out = 0;
    int waited = 0;
    logic [CNT_W-1:0] m_sc = 0, m_fc = 0;
    logic [7:0] e;

    // e bits: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush mem_timeout
    function automatic logic [7:0] expect_out();
        bit lu, stall_all;
        lu = ex_regwrite && ex_wdsel == 2'b01 && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        stall_all = halted || (waiting ? !mem_ready : (mem_req && !mem_ready));
        if (rst) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, timed_out};
        if (stall_all) return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, timed_out};
        if (ex_branch_taken) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, timed_out};
        if (lu) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, timed_out};
        return {7'b0, timed_out};
    endfunction

    task automatic cycle();
        exp_t x;
        e = expect_out();
        x.cyc = cyc; x.o = e; x.sc = m_sc; x.fc = m_fc;
        sb.push_back(x);
        @(posedge clk);
        if (rst) begin
            waiting = 0; halted = 0; timed_out = 0; waited = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_sc = m_sc + CNT_W'(e[7]);
            m_fc = m_fc + CNT_W'(e[5] | e[3]);
            if (!halted) begin
                if (waiting) begin
                    if (mem_ready) waiting = 0;
                    else begin
                        if (waited == MAX_WAIT) begin timed_out = 1; halted = 1; waiting = 0; end
                        waited++;
                    end
                end else if (mem_req && !mem_ready) begin
                    waiting = 1; waited = 1;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                          input bit rw, input int wd, input bit br, input bit mreq, input bit mrdy);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = 5'(rd);
        ex_regwrite = rw; ex_wdsel = 2'(wd); ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        cycle();
    endtask

    task automatic idle(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if ({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, mem_timeout} === x.o) passed++;
                else $display("FAIL outs cyc %0d got %b exp %b", x.cyc,
                    {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, mem_timeout}, x.o);
                checks++;
                if (stall_cnt === x.sc) passed++;
                else $display("FAIL stall_cnt cyc %0d got %0d exp %0d", x.cyc, stall_cnt, x.sc);
                checks++;
                if (flush_cnt === x.fc) passed++;
                else $display("FAIL flush_cnt cyc %0d got %0d exp %0d", x.cyc, flush_cnt, x.fc);
            end
        end
    end

    initial begin : driver
        @(posedge clk); #1;
        rst = 1; idle(); idle();
        rst = 0; idle();
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        idle();
        set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        set_in(5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        set_in(0, 7, 0, 1, 7, 1, 1, 0, 0, 0);
        set_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        idle();
        repeat (3) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle();
        set_in(3, 0, 1, 0, 3, 1, 1, 0, 1, 0);
        set_in(3, 0, 1, 0, 3, 1, 1, 0, 1, 1);
        idle();
        repeat (8) set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        set_in(5, 0, 1, 0, 5, 1, 1, 1, 0, 1);
        rst = 1; idle();
        rst = 0; idle(); idle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 55);
        end
        rst = 0; idle();
        @(negedge clk); #1;
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
